crossbar_pipe: RTL

- Parametrised successor to the router's combinational crossbar: a PORT_NUM x PORT_NUM flit switch with a configurable output pipeline depth and per-output valid tracking.
- Adds per-output saturating flit counters, an optional multicast mode, and sticky error flags for illegal selections.
- Sits between input_block (flit source) and the output links. Switch allocator supplies per-output input selects and grant-valid bits.

---
 rtl/crossbar_pipe_pkg.sv | 10 +
 rtl/xbar_pipe_stage.sv | 38 +++
 rtl/crossbar_pipe.sv | 123 ++++++++++++
 3 files changed

// File: rtl/crossbar_pipe_pkg.sv
// Shared NoC parameters: flit type, port count and select width.
package crossbar_pipe_pkg;

    localparam int unsigned FLIT_W   = 16;
    localparam int unsigned PORT_NUM = 5;
    localparam int unsigned SEL_W    = $clog2(PORT_NUM);

    typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/xbar_pipe_stage.sv
// One output register stage: PORT_NUM flits plus their valid bits, synchronous reset.
module xbar_pipe_stage
    import crossbar_pipe_pkg::*;
#(
    parameter int unsigned PORT_NUM = crossbar_pipe_pkg::PORT_NUM
) (
    input  logic                clk,
    input  logic                rst,
    input  flit_t [PORT_NUM-1:0] data_i,
    input  logic [PORT_NUM-1:0] valid_i,
    output flit_t [PORT_NUM-1:0] data_o,
    output logic [PORT_NUM-1:0] valid_o
);

    flit_t [PORT_NUM-1:0] data_d, data_q;
    logic  [PORT_NUM-1:0] valid_d, valid_q;

    // No stall: every stage loads every cycle, data included even when invalid.
    always_comb begin
        data_d  = data_i;
        valid_d = valid_i;
    end

    // Stage registers; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/crossbar_pipe.sv
// PORT_NUM x PORT_NUM flit switch with PIPE_STAGES output registers,
// per-output saturating flit counters and sticky selection error flags.
module crossbar_pipe
    import crossbar_pipe_pkg::*;
#(
    parameter int unsigned PORT_NUM    = crossbar_pipe_pkg::PORT_NUM,
    parameter int unsigned PIPE_STAGES = 1,
    parameter int unsigned CNT_W       = 16,
    parameter bit          MCAST_EN    = 1'b0,
    parameter int unsigned SEL_W       = $clog2(PORT_NUM)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  flit_t [PORT_NUM-1:0]             flit_i,
    input  logic  [PORT_NUM-1:0][SEL_W-1:0]  sel_i,
    input  logic  [PORT_NUM-1:0]             sel_valid_i,
    input  logic                             clr_cnt_i,
    output flit_t [PORT_NUM-1:0]             data_o,
    output logic  [PORT_NUM-1:0]             valid_o,
    output logic  [PORT_NUM-1:0][CNT_W-1:0]  cnt_o,
    output logic  [1:0]                      err_o
);

    if (PIPE_STAGES > 3 || PORT_NUM < 2) begin : g_bad_cfg
        $fatal(1, "crossbar_pipe: PIPE_STAGES must be 0..3 and PORT_NUM >= 2");
    end

    localparam logic [CNT_W-1:0] CntMax = '1;

    flit_t [PORT_NUM-1:0] mux_data;
    logic  [PORT_NUM-1:0] mux_valid;
    logic  [PORT_NUM-1:0] sel_oor;
    logic                 conflict;

    // Stage 0: per-output input mux; invalid or out-of-range selects give zero.
    always_comb begin
        mux_data  = '0;
        mux_valid = '0;
        sel_oor   = '0;
        for (int unsigned o = 0; o < PORT_NUM; o++) begin
            if (sel_valid_i[o]) begin
                if (32'(sel_i[o]) < PORT_NUM) begin
                    mux_valid[o] = 1'b1;
                    mux_data[o]  = flit_i[sel_i[o]];
                end else begin
                    sel_oor[o] = 1'b1;
                end
            end
        end
    end

    // Conflict: any two valid in-range selects naming the same input.
    always_comb begin
        conflict = 1'b0;
        for (int unsigned a = 0; a < PORT_NUM; a++) begin
            for (int unsigned b = a + 1; b < PORT_NUM; b++) begin
                if (mux_valid[a] && mux_valid[b] && (sel_i[a] == sel_i[b])) begin
                    conflict = 1'b1;
                end
            end
        end
    end

    // Stage chain; index 0 is the combinational mux output.
    flit_t [PORT_NUM-1:0] stg_data  [PIPE_STAGES+1];
    logic  [PORT_NUM-1:0] stg_valid [PIPE_STAGES+1];

    assign stg_data[0]  = mux_data;
    assign stg_valid[0] = mux_valid;

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        xbar_pipe_stage #(
            .PORT_NUM (PORT_NUM)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .data_i  (stg_data[s]),
            .valid_i (stg_valid[s]),
            .data_o  (stg_data[s+1]),
            .valid_o (stg_valid[s+1])
        );
    end

    assign data_o  = stg_data[PIPE_STAGES];
    assign valid_o = stg_valid[PIPE_STAGES];

    logic [PORT_NUM-1:0][CNT_W-1:0] cnt_d, cnt_q;
    logic [1:0]                     err_d, err_q;

    // Counters count at the output side; clear wins over a same-edge increment.
    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned o = 0; o < PORT_NUM; o++) begin
            if (clr_cnt_i) begin
                cnt_d[o] = '0;
            end else if (valid_o[o] && (cnt_q[o] != CntMax)) begin
                cnt_d[o] = cnt_q[o] + CNT_W'(1);
            end
        end
    end

    // Sticky error flags: [1] out-of-range select, [0] conflict unless multicast allowed.
    always_comb begin
        err_d    = err_q;
        err_d[1] = err_q[1] | (|sel_oor);
        err_d[0] = err_q[0] | (conflict & ~MCAST_EN);
    end

    // Counter and error state, always registered regardless of pipeline depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = err_q;

endmodule
